mult_share_ctrl: RTL and testbench
==================================

// Module: mult_share_ctrl
// PURPOSE
// Shares one 4x4 shift-add multiplier between N_REQ requesters. It arbitrates
// round-robin and latches the winner's operands. It then pulses the multiplier's
// start, waits for done, and returns the 8-bit product to the winner with a
// one-cycle valid pulse. It sits between the requester fabric and a single
// multiplier instance; the multiplier itself has no reset.
// PARAMETERS
// N_REQ     4   number of requesters (2..8)
// DRAIN_CYC 10  cycles held in DRAIN after reset; covers the longest multiplier run plus return to idle
// TIMEOUT   15  max cycles in WAIT before the error is flagged
// PORTS
// clk         in   1        system clock, rising edge
// rst         in   1        asynchronous, active-high reset
// req         in   N_REQ    per-requester request, level, held until its rsp_valid
// a_in        in   4*N_REQ  multiplier operand, requester i at [4i+3:4i]
// b_in        in   4*N_REQ  multiplicand operand, requester i at [4i+3:4i]
// gnt         out  N_REQ    one-hot owner of the multiplier, START..RESP
// rsp_valid   out  N_REQ    one-cycle pulse to owner, rsp_prod valid
// rsp_prod    out  8        product a*b of last completed operation
// busy        out  1        high in every state except IDLE
// err         out  1        sticky timeout flag, cleared only by rst
// mult_st     out  1        start to multiplier
// mult_mplier out  4        latched multiplier operand
// mult_mcand  out  4        latched multiplicand operand
// mult_done   in   1        multiplier done (high one cycle)
// mult_acc    in   9        multiplier accumulator; product = mult_acc[7:0]
// BEHAVIOUR
// Reset values: state=DRAIN; every output 0 (gnt, rsp_valid, rsp_prod, busy=1 in DRAIN, err, mult_*); rr_ptr=0.
// Reset mid-operation: the controller goes to DRAIN at once and drops gnt with no rsp_valid.
//   The multiplier finishes on its own; DRAIN absorbs it. mult_done is ignored in DRAIN.
// FSM, one transition per clk:
//  DRAIN: count DRAIN_CYC cycles with mult_st=0, req ignored -> IDLE.
//  IDLE : no req -> stay. Else pick the first set req at or above rr_ptr, wrapping mod N_REQ.
//         Latch that requester's a/b into mult_mplier/mult_mcand, set gnt one-hot -> START.
//  START: mult_st=1 for exactly this cycle -> WAIT. The multiplier is idle here by construction.
//  WAIT : mult_done=1 -> capture rsp_prod<=mult_acc[7:0] -> RESP.
//         Timeout counter reaches TIMEOUT -> err<=1, rsp_prod<=0 -> RESP.
//  RESP : rsp_valid[owner]=1 for this cycle; rr_ptr<=(owner+1) mod N_REQ -> IDLE, gnt cleared.
// Latency: gnt rises at the edge leaving IDLE. rsp_valid comes 8..12 cycles later.
//   The minimum applies when mplier=0 (5-cycle multiplier run); the maximum when mplier=4'hF (9-cycle run).
// Back-to-back: re-arbitration in IDLE always costs one cycle. This guarantees the multiplier is back at idle before the next mult_st.
// Operands are sampled only in IDLE; later changes on a_in/b_in are ignored.
// If req drops during an operation, the result is still computed and rsp_valid still pulses.
// If req rises for the owner again in RESP, it is treated as a new request next IDLE, subject to round-robin.
// Simultaneous req: exactly one grant, never two. Fairness: a requester waits at most N_REQ-1 operations.
// Arithmetic: 4x4 unsigned, product max 225 fits in 8 bits; mult_acc[8] is ignored.
// rsp_prod holds its value until the next capture.
// TESTING
// T1: reset, wait DRAIN; req[0] with a=3,b=5 -> gnt=0001, one mult_st pulse, rsp_valid[0] with rsp_prod=15.
// T2: a=4'hF, b=4'hF -> rsp_prod=225, latency 12 cycles. a=0, b=7 -> rsp_prod=0, latency 8.
// T3: req=1111 held, operands i*2 and 3 -> grants go 0,1,2,3,0. Products 0,6,12,18, one rsp_valid per op.
// T4: rst asserted 3 cycles after mult_st -> all outputs 0 at once, no rsp_valid.
//     After DRAIN, a new request 6x7 -> 42 correct.
// T5: mult_done tied 0 -> err=1 after TIMEOUT, rsp_valid pulses with rsp_prod=0. err stays set until rst.
// T6: req[2] dropped and a_in changed mid-operation -> rsp_valid[2] still pulses with the originally latched product.

Source files
------------

// File: rtl/mult_share_ctrl.sv
// Round-robin controller that lends one 4x4 shift-add multiplier to N_REQ requesters.
// Operands are latched at grant time; the product returns to the owner with a one-cycle valid.
module mult_share_ctrl #(
   parameter int N_REQ     = 4,
   parameter int DRAIN_CYC = 10,
   parameter int TIMEOUT   = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [4*N_REQ-1:0]   a_in,
   input  logic [4*N_REQ-1:0]   b_in,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     rsp_valid,
   output logic [7:0]           rsp_prod,
   output logic                 busy,
   output logic                 err,
   output logic                 mult_st,
   output logic [3:0]           mult_mplier,
   output logic [3:0]           mult_mcand,
   input  logic                 mult_done,
   input  logic [8:0]           mult_acc
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = PW + 1;
   localparam int DW = $clog2(DRAIN_CYC + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int unsigned NR = N_REQ;

   typedef enum logic [2:0] {
      ST_DRAIN,
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t           r_state;
   logic [DW-1:0]    r_drain_cnt;
   logic [TW-1:0]    r_tmo_cnt;
   logic [PW-1:0]    r_rr_ptr;
   logic [PW-1:0]    r_owner;
   logic [N_REQ-1:0] r_gnt;
   logic [N_REQ-1:0] r_rsp_valid;
   logic [7:0]       r_rsp_prod;
   logic             r_busy;
   logic             r_err;
   logic             r_mult_st;
   logic [3:0]       r_mplier;
   logic [3:0]       r_mcand;

   logic             w_found;
   logic [PW-1:0]    w_pick;
   logic [N_REQ-1:0] w_pick_oh;
   logic [PW-1:0]    w_next_ptr;
   logic [3:0]       w_a_arr [N_REQ];
   logic [3:0]       w_b_arr [N_REQ];
   logic             w_unused_acc;

   // Bit 8 of the accumulator is a carry the 4x4 product never needs.
   assign w_unused_acc = mult_acc[8];

   for (genvar g = 0; g < N_REQ; g++) begin : g_ops
      assign w_a_arr[g] = a_in[4*g +: 4];
      assign w_b_arr[g] = b_in[4*g +: 4];
   end

   // Search upward from the round-robin pointer; CW bits keep ptr+i from wrapping early.
   always_comb begin
      logic [CW-1:0] cand;
      cand    = '0;
      w_found = 1'b0;
      w_pick  = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         cand = {1'b0, r_rr_ptr} + CW'(i);
         if (cand >= CW'(N_REQ)) begin
            cand = cand - CW'(N_REQ);
         end
         if (!w_found && req[cand[PW-1:0]]) begin
            w_found = 1'b1;
            w_pick  = cand[PW-1:0];
         end
      end
   end

   always_comb begin
      w_pick_oh         = '0;
      w_pick_oh[w_pick] = 1'b1;
   end

   assign w_next_ptr = (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_DRAIN;
         r_drain_cnt <= '0;
         r_tmo_cnt   <= '0;
         r_rr_ptr    <= '0;
         r_owner     <= '0;
         r_gnt       <= '0;
         r_rsp_valid <= '0;
         r_rsp_prod  <= '0;
         r_busy      <= 1'b1;
         r_err       <= 1'b0;
         r_mult_st   <= 1'b0;
         r_mplier    <= '0;
         r_mcand     <= '0;
      end else begin
         r_mult_st   <= 1'b0;
         r_rsp_valid <= '0;
         unique case (r_state)
            // Lets a multiplier run orphaned by reset finish; its done is ignored here.
            ST_DRAIN: begin
               if (r_drain_cnt == DW'(DRAIN_CYC - 1)) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_drain_cnt <= r_drain_cnt + 1'b1;
               end
            end
            ST_IDLE: begin
               if (w_found) begin
                  r_owner   <= w_pick;
                  r_gnt     <= w_pick_oh;
                  r_mplier  <= w_a_arr[w_pick];
                  r_mcand   <= w_b_arr[w_pick];
                  r_mult_st <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= ST_START;
               end
            end
            ST_START: begin
               r_tmo_cnt <= '0;
               r_state   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mult_done) begin
                  r_rsp_prod  <= mult_acc[7:0];
                  r_rsp_valid <= r_gnt;
                  r_state     <= ST_RESP;
               end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
                  r_err       <= 1'b1;
                  r_rsp_prod  <= '0;
                  r_rsp_valid <= r_gnt;
                  r_state     <= ST_RESP;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               r_rr_ptr <= w_next_ptr;
               r_gnt    <= '0;
               r_busy   <= 1'b0;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_drain_cnt <= '0;
               r_gnt       <= '0;
               r_busy      <= 1'b1;
               r_state     <= ST_DRAIN;
            end
         endcase
      end
   end

   assign gnt         = r_gnt;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_prod    = r_rsp_prod;
   assign busy        = r_busy;
   assign err         = r_err;
   assign mult_st     = r_mult_st;
   assign mult_mplier = r_mplier;
   assign mult_mcand  = r_mcand;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl with a timing model of the shared shift-add multiplier.
module tb_mult_share_ctrl;

   localparam int N     = 4;
   localparam int DRAIN = 10;
   localparam int TMO   = 15;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [4*N-1:0] a_in;
   logic [4*N-1:0] b_in;
   logic [N-1:0]   gnt;
   logic [N-1:0]   rsp_valid;
   logic [7:0]     rsp_prod;
   logic           busy;
   logic           err;
   logic           mult_st;
   logic [3:0]     mult_mplier;
   logic [3:0]     mult_mcand;
   logic           mult_done;
   logic [8:0]     mult_acc;

   mult_share_ctrl #(
      .N_REQ(N),
      .DRAIN_CYC(DRAIN),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .a_in(a_in),
      .b_in(b_in),
      .gnt(gnt),
      .rsp_valid(rsp_valid),
      .rsp_prod(rsp_prod),
      .busy(busy),
      .err(err),
      .mult_st(mult_st),
      .mult_mplier(mult_mplier),
      .mult_mcand(mult_mcand),
      .mult_done(mult_done),
      .mult_acc(mult_acc)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int a;
      int b;
      int prod;
      int lat;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   m_ptr   = 0;
   int   op_a[N];
   int   op_b[N];
   bit   m_done_en = 1'b1;

   task automatic chk(input string name, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   always @(posedge clk) cyc++;

   // Multiplier model: no reset; done arrives 7+popcount(mplier) negedges after seeing start.
   int         m_cnt = 0;
   logic [7:0] m_prod = '0;
   always @(negedge clk) begin
      mult_done = 1'b0;
      if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0 && m_done_en) begin
            mult_done = 1'b1;
            mult_acc  = {1'($urandom), m_prod};
         end
      end
      if (mult_st) begin
         m_cnt  = 7 + $countones(mult_mplier);
         m_prod = 8'(mult_mplier) * 8'(mult_mcand);
      end
      if (!mult_done) mult_acc = 9'($urandom);
   end

   // Monitor: pops the scoreboard on every rsp_valid pulse.
   logic [N-1:0] prev_gnt = '0;
   int           g_cyc = 0;
   int           st_cnt = 0;
   exp_t         me;
   always @(negedge clk) begin
      if (rst) begin
         prev_gnt = '0;
         st_cnt   = 0;
      end else begin
         if (gnt != '0 && prev_gnt == '0) begin
            g_cyc  = cyc;
            st_cnt = 0;
            chk("gnt_onehot", $countones(gnt), 1);
         end
         if (mult_st) begin
            st_cnt++;
            if (q.size() > 0) begin
               chk("st_mplier", mult_mplier, q[0].a);
               chk("st_mcand", mult_mcand, q[0].b);
               chk("st_gnt", gnt, 1 << q[0].idx);
            end
         end
         if (rsp_valid != '0) begin
            if (q.size() == 0) begin
               chk("rsp_unexpected", rsp_valid, 0);
            end else begin
               me = q.pop_front();
               chk("rsp_owner", rsp_valid, 1 << me.idx);
               chk("rsp_prod", rsp_prod, me.prod);
               chk("rsp_latency", cyc - g_cyc, me.lat);
               chk("st_pulses", st_cnt, 1);
            end
         end
         prev_gnt = gnt;
      end
   end

   // Reference arbitration: one batch of simultaneous requests is served in
   // ascending order starting at the pointer, wrapping modulo N.
   task automatic push_round(input logic [N-1:0] mask, output int last_prod);
      int last;
      last      = m_ptr;
      last_prod = 0;
      for (int k = 0; k < N; k++) begin
         int   j;
         exp_t e;
         j = (m_ptr + k) % N;
         if (mask[j]) begin
            e.idx  = j;
            e.a    = op_a[j];
            e.b    = op_b[j];
            e.prod = m_done_en ? op_a[j] * op_b[j] : 0;
            e.lat  = m_done_en ? 8 + $countones(4'(op_a[j])) : 1 + TMO;
            q.push_back(e);
            last      = j;
            last_prod = e.prod;
         end
      end
      m_ptr = (last + 1) % N;
   endtask

   task automatic drive_ops(input logic [N-1:0] mask);
      for (int j = 0; j < N; j++) begin
         if (mask[j]) begin
            a_in[4*j +: 4] = 4'(op_a[j]);
            b_in[4*j +: 4] = 4'(op_b[j]);
         end
      end
   endtask

   task automatic run_round(input logic [N-1:0] mask, input bit drop_mid);
      logic [N-1:0] pending;
      int           budget;
      int           lp;
      bit           dropped;
      drive_ops(mask);
      push_round(mask, lp);
      pending = mask;
      req     = req | mask;
      budget  = 25 * $countones(mask) + 30;
      dropped = 1'b0;
      while (pending != '0 && budget > 0) begin
         @(negedge clk);
         budget--;
         if (drop_mid && !dropped && mult_st) begin
            req = req & ~mask;
            for (int j = 0; j < N; j++) begin
               if (mask[j]) begin
                  a_in[4*j +: 4] = ~4'(op_a[j]);
                  b_in[4*j +: 4] = 4'($urandom);
               end
            end
            dropped = 1'b1;
         end
         pending = pending & ~rsp_valid;
         req     = req & ~rsp_valid;
      end
      if (pending != '0) begin
         chk("round_done", pending, 0);
         req = '0;
         q.delete();
      end
      repeat (2) @(negedge clk);
      chk("prod_hold", rsp_prod, lp);
      chk("idle_busy", busy, 0);
      chk("idle_gnt", gnt, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      q.delete();
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_prod", rsp_prod, 0);
      chk("rst_busy", busy, 1);
      chk("rst_err", err, 0);
      chk("rst_mult_st", mult_st, 0);
      chk("rst_mplier", mult_mplier, 0);
      chk("rst_mcand", mult_mcand, 0);
      @(negedge clk);
      @(negedge clk);
      m_ptr = 0;
      req   = 4'b0110;
      rst   = 1'b0;
      repeat (DRAIN - 1) @(posedge clk);
      #1;
      chk("drain_busy", busy, 1);
      chk("drain_gnt", gnt, 0);
      req = '0;
      @(posedge clk);
      #1;
      chk("drain_exit", busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] mask;
      int           lp;
      bit           seen;
      rst       = 1'b0;
      req       = '0;
      a_in      = '0;
      b_in      = '0;
      mult_done = 1'b0;
      mult_acc  = '0;
      #1 rst = 1'b1;
      do_reset();

      op_a[0] = 3;  op_b[0] = 5;  run_round(4'b0001, 1'b0);
      op_a[1] = 15; op_b[1] = 15; run_round(4'b0010, 1'b0);
      op_a[2] = 0;  op_b[2] = 7;  run_round(4'b0100, 1'b0);
      op_a[3] = 1;  op_b[3] = 1;  run_round(4'b1000, 1'b0);

      for (int i = 0; i < N; i++) begin
         op_a[i] = i * 2;
         op_b[i] = 3;
      end
      run_round(4'b1111, 1'b0);
      run_round(4'b0001, 1'b0);

      // Reset three cycles after the start pulse.
      op_a[1] = 9; op_b[1] = 9;
      drive_ops(4'b0010);
      push_round(4'b0010, lp);
      req  = 4'b0010;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         seen = mult_st;
      end
      chk("midrst_start_seen", seen, 1);
      repeat (3) @(negedge clk);
      do_reset();
      op_a[3] = 6; op_b[3] = 7;
      run_round(4'b1000, 1'b0);

      m_done_en = 1'b0;
      op_a[1] = 5; op_b[1] = 5;
      run_round(4'b0010, 1'b0);
      chk("err_set", err, 1);
      m_done_en = 1'b1;
      op_a[0] = 2; op_b[0] = 11;
      run_round(4'b0001, 1'b0);
      chk("err_sticky", err, 1);
      do_reset();

      op_a[2] = 5; op_b[2] = 9;
      run_round(4'b0100, 1'b1);

      for (int r = 0; r < 40; r++) begin
         mask = 4'($urandom_range(1, 15));
         for (int j = 0; j < N; j++) begin
            op_a[j] = $urandom_range(0, 15);
            op_b[j] = $urandom_range(0, 15);
         end
         run_round(mask, 1'b0);
      end
      chk("final_err", err, 0);
      chk("queue_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
